flux_capture_sequencer: RTL and testbench

Host-facing controller that sequences the AXI-Stream flux capture engine for one multi-revolution track read. On a start command it flushes the engine with a one-cycle soft reset and waits a head-settle time. It then aligns to the next index pulse, enables capture for N revolutions, and waits for the stream FIFO to drain. It reports done or an error code. It sits between the register file and the flux capture engine, and drives that engine's capture_enable, capture_mode and soft_reset.

---
 rtl/flux_ctrl_pkg.sv | 26 ++
 rtl/flux_seq_timer.sv | 33 +++
 rtl/flux_capture_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_flux_capture_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flux_ctrl_pkg.sv
// Shared definitions for the flux capture sequencer: state encoding,
// error codes reported to the host, and capture_mode values for the engine.
package flux_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FLUSH      = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_WAIT_INDEX = 3'd3,
        ST_CAPTURE    = 3'd4,
        ST_DRAIN      = 3'd5,
        ST_DONE       = 3'd6,
        ST_ERROR      = 3'd7
    } seq_state_t;

    localparam logic [2:0] ERR_NONE          = 3'd0;
    localparam logic [2:0] ERR_OVERFLOW      = 3'd1;
    localparam logic [2:0] ERR_INDEX_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_DRAIN_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_ABORT         = 3'd4;

    localparam logic [1:0] MODE_CONT      = 2'b00;
    localparam logic [1:0] MODE_ONE_TRACK = 2'b01;
    localparam logic [1:0] MODE_ONE_REV   = 2'b10;

endpackage

// File: rtl/flux_seq_timer.sv
// Shared up-counter for settle, index-wait and drain timing.
// hit fires in the cycle whose 1-based count equals limit; limit 0 disables it.
// The counter saturates at all-ones so it can never wrap back onto the limit.
module flux_seq_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    logic [CNT_W:0] count_inc;

    // Compare the number of the current cycle (count + 1) against the limit.
    always_comb begin
        count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
        hit       = run && (limit != '0) && (count_inc == {1'b0, limit});
    end

    // Count running cycles; restart from zero whenever the sequencer changes state.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (run && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/flux_capture_sequencer.sv
// Sequences one multi-revolution track read on the flux capture engine:
// flush, head settle, index alignment, capture for N revolutions, drain.
//
// Command semantics: start and abort are single-cycle strobes with no ready
// handshake. start is taken only in IDLE with abort low; abort is taken in any
// non-IDLE state and outranks every other event in the same cycle.
module flux_capture_sequencer
    import flux_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REV_W = 8
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    input  logic             abort,
    input  logic [REV_W-1:0] num_revs,
    input  logic [CNT_W-1:0] settle_cycles,
    input  logic [CNT_W-1:0] timeout_cycles,
    input  logic             index_pulse,
    input  logic             overflow,
    input  logic             fifo_empty,
    input  logic [31:0]      capture_count,
    output logic             capture_enable,
    output logic [1:0]       capture_mode,
    output logic             soft_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       error_code,
    output logic [REV_W-1:0] revs_done,
    output logic [31:0]      flux_words,
    output logic [2:0]       seq_state
);

    seq_state_t       state, state_next;
    logic             index_q;
    logic             index_evt;
    logic [REV_W-1:0] num_revs_q;
    logic [CNT_W-1:0] settle_q;
    logic [CNT_W-1:0] timeout_q;

    logic             start_accept;
    logic             timer_run;
    logic             timer_clear;
    logic [CNT_W-1:0] timer_limit;
    logic [CNT_W-1:0] timer_count;
    logic             timer_hit;

    logic             err_set;
    logic [2:0]       err_code_set;
    logic             rev_step;
    logic [REV_W-1:0] rev_next;
    logic [REV_W-1:0] rev_target;

    flux_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (aclk),
        .rst   (areset),
        .clear (timer_clear),
        .run   (timer_run),
        .limit (timer_limit),
        .count (timer_count),
        .hit   (timer_hit)
    );

    // Rising edge of index_pulse acts in the same cycle it is first seen high.
    always_comb begin
        index_evt    = index_pulse && !index_q;
        start_accept = (state == ST_IDLE) && start && !abort;
        rev_next     = (revs_done == '1) ? revs_done : revs_done + 1'b1;
        rev_target   = (num_revs_q == '0) ? {{(REV_W-1){1'b0}}, 1'b1} : num_revs_q;
    end

    // Next-state decode; abort is applied last so it overrides every other event.
    always_comb begin
        state_next   = state;
        timer_run    = 1'b0;
        timer_limit  = timeout_q;
        err_set      = 1'b0;
        err_code_set = ERR_NONE;
        rev_step     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_accept) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_next = (settle_q != '0) ? ST_SETTLE : ST_WAIT_INDEX;
            end
            ST_SETTLE: begin
                timer_run   = 1'b1;
                timer_limit = settle_q;
                if (timer_hit) state_next = ST_WAIT_INDEX;
            end
            ST_WAIT_INDEX: begin
                timer_run = 1'b1;
                if (index_evt) begin
                    state_next = ST_CAPTURE;
                end else if (timer_hit) begin
                    state_next   = ST_ERROR;
                    err_set      = 1'b1;
                    err_code_set = ERR_INDEX_TIMEOUT;
                end
            end
            ST_CAPTURE: begin
                if (overflow) begin
                    state_next   = ST_ERROR;
                    err_set      = 1'b1;
                    err_code_set = ERR_OVERFLOW;
                end else if (index_evt) begin
                    rev_step = 1'b1;
                    if (rev_next == rev_target) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                timer_run = 1'b1;
                // The engine may still report empty from before the last words
                // landed, so the first drain cycle never trusts fifo_empty.
                if (fifo_empty && (timer_count != '0)) begin
                    state_next = ST_DONE;
                end else if (timer_hit) begin
                    state_next   = ST_ERROR;
                    err_set      = 1'b1;
                    err_code_set = ERR_DRAIN_TIMEOUT;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ERROR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        if ((state != ST_IDLE) && abort) begin
            state_next   = ST_ERROR;
            err_set      = 1'b1;
            err_code_set = ERR_ABORT;
            rev_step     = 1'b0;
        end
    end

    // Timer restarts whenever the state changes.
    always_comb begin
        timer_clear = (state_next != state);
    end

    // Engine-facing and host-facing outputs decoded from the registered state.
    always_comb begin
        capture_enable = (state == ST_CAPTURE);
        capture_mode   = MODE_CONT;
        soft_reset     = (state == ST_FLUSH) || (state == ST_ERROR);
        busy           = (state != ST_IDLE);
        done           = (state == ST_DONE);
        seq_state      = state;
    end

    // State register and index edge-detect stage.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= ST_IDLE;
            index_q <= 1'b0;
        end else begin
            state   <= state_next;
            index_q <= index_pulse;
        end
    end

    // Run configuration is captured once at start so the host can reprogram freely.
    always_ff @(posedge aclk) begin
        if (areset) begin
            num_revs_q <= '0;
            settle_q   <= '0;
            timeout_q  <= '0;
        end else if (start_accept) begin
            num_revs_q <= num_revs;
            settle_q   <= settle_cycles;
            timeout_q  <= timeout_cycles;
        end
    end

    // Status registers: sticky error, revolution count, latched word count.
    always_ff @(posedge aclk) begin
        if (areset) begin
            error      <= 1'b0;
            error_code <= ERR_NONE;
            revs_done  <= '0;
            flux_words <= '0;
        end else begin
            if (start_accept) begin
                error      <= 1'b0;
                error_code <= ERR_NONE;
                revs_done  <= '0;
            end
            if (rev_step) revs_done <= rev_next;
            if (err_set) begin
                error      <= 1'b1;
                error_code <= err_code_set;
            end
            if ((state_next == ST_DONE) && (state != ST_DONE)) begin
                flux_words <= capture_count;
            end
        end
    end

endmodule

// File: tb/tb_flux_capture_sequencer.sv
// Directed bench for flux_capture_sequencer with a small engine stub that
// counts capture cycles and clears on soft_reset.
module tb_flux_capture_sequencer;
    import flux_ctrl_pkg::*;

    localparam int CNT_W = 32;
    localparam int REV_W = 8;

    logic             aclk = 1'b0;
    logic             areset;
    logic             start;
    logic             abort;
    logic [REV_W-1:0] num_revs;
    logic [CNT_W-1:0] settle_cycles;
    logic [CNT_W-1:0] timeout_cycles;
    logic             index_pulse;
    logic             overflow;
    logic             fifo_empty;
    logic [31:0]      capture_count;
    logic             capture_enable;
    logic [1:0]       capture_mode;
    logic             soft_reset;
    logic             busy;
    logic             done;
    logic             error;
    logic [2:0]       error_code;
    logic [REV_W-1:0] revs_done;
    logic [31:0]      flux_words;
    logic [2:0]       seq_state;

    int compared   = 0;
    int mismatched = 0;

    flux_capture_sequencer #(.CNT_W(CNT_W), .REV_W(REV_W)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .start          (start),
        .abort          (abort),
        .num_revs       (num_revs),
        .settle_cycles  (settle_cycles),
        .timeout_cycles (timeout_cycles),
        .index_pulse    (index_pulse),
        .overflow       (overflow),
        .fifo_empty     (fifo_empty),
        .capture_count  (capture_count),
        .capture_enable (capture_enable),
        .capture_mode   (capture_mode),
        .soft_reset     (soft_reset),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .error_code     (error_code),
        .revs_done      (revs_done),
        .flux_words     (flux_words),
        .seq_state      (seq_state)
    );

    // Clock
    always #5 aclk = ~aclk;

    // Engine stub: one flux word per enabled cycle, flushed by soft_reset.
    always @(posedge aclk) begin
        if (areset || soft_reset) capture_count <= 32'd0;
        else if (capture_enable)  capture_count <= capture_count + 32'd1;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; afterwards the DUT is in FLUSH.
    task automatic do_start(input logic [REV_W-1:0] nr, input logic [CNT_W-1:0] st,
                            input logic [CNT_W-1:0] to);
        num_revs       = nr;
        settle_cycles  = st;
        timeout_cycles = to;
        start          = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // One-cycle index pulse seen at the next edge.
    task automatic pulse_index();
        index_pulse = 1'b1;
        step(1);
        index_pulse = 1'b0;
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; abort = 1'b0; num_revs = '0;
        settle_cycles = '0; timeout_cycles = '0; index_pulse = 1'b0;
        overflow = 1'b0; fifo_empty = 1'b0;
        step(3);
        check("rst_busy", busy, 0);
        check("rst_cap_en", capture_enable, 0);
        check("rst_mode", capture_mode, 2'b00);
        check("rst_soft_reset", soft_reset, 0);
        check("rst_error", {error, error_code}, 0);
        check("rst_revs", revs_done, 0);
        check("rst_flux_words", flux_words, 0);
        areset = 1'b0;
        step(2);

        // Normal run: 2 revolutions, settle 50, index every 2000 cycles.
        do_start(8'd2, 32'd50, 32'd10000);
        check("n_flush_sr", soft_reset, 1);
        check("n_flush_busy", busy, 1);
        step(1);
        check("n_settle_sr", soft_reset, 0);
        check("n_settle_state", seq_state, ST_SETTLE);
        step(49);
        check("n_settle_last", seq_state, ST_SETTLE);
        step(1);
        check("n_wait_state", seq_state, ST_WAIT_INDEX);
        step(100);
        check("n_wait_cap_en", capture_enable, 0);
        pulse_index();
        check("n_cap_en_rise", capture_enable, 1);
        step(1999);
        pulse_index();
        check("n_rev1", revs_done, 1);
        check("n_rev1_cap_en", capture_enable, 1);
        step(1999);
        pulse_index();
        check("n_rev2", revs_done, 2);
        check("n_drain_cap_en", capture_enable, 0);
        step(4);
        check("n_drain_no_done", done, 0);
        fifo_empty = 1'b1;
        step(1);
        check("n_done", done, 1);
        check("n_flux_words", flux_words, 32'd4000);
        step(1);
        check("n_done_once", done, 0);
        check("n_idle_busy", busy, 0);
        check("n_no_error", error, 0);

        // Index timeout after 300 cycles of WAIT_INDEX.
        fifo_empty = 1'b0;
        do_start(8'd1, 32'd0, 32'd300);
        step(1);
        check("it_wait", seq_state, ST_WAIT_INDEX);
        step(299);
        check("it_not_yet", error, 0);
        check("it_cap_en_299", capture_enable, 0);
        step(1);
        check("it_error", error, 1);
        check("it_code", error_code, ERR_INDEX_TIMEOUT);
        check("it_sr", soft_reset, 1);
        check("it_cap_en", capture_enable, 0);
        step(1);
        check("it_idle", busy, 0);
        check("it_sticky", error, 1);

        // Overflow coincident with the final index.
        do_start(8'd1, 32'd0, 32'd10000);
        check("ov_start_clr", error, 0);
        step(1);
        step(10);
        pulse_index();
        check("ov_cap_en", capture_enable, 1);
        step(99);
        overflow = 1'b1;
        index_pulse = 1'b1;
        step(1);
        overflow = 1'b0;
        index_pulse = 1'b0;
        check("ov_code", error_code, ERR_OVERFLOW);
        check("ov_cap_en_low", capture_enable, 0);
        check("ov_no_done", done, 0);
        check("ov_revs", revs_done, 0);
        step(1);
        check("ov_idle_no_done", {busy, done}, 0);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("ab_idle_busy", busy, 0);
        check("ab_idle_code", error_code, ERR_OVERFLOW);

        // Abort during SETTLE.
        do_start(8'd1, 32'd50, 32'd10000);
        step(1);
        step(10);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("ab_settle_code", error_code, ERR_ABORT);
        check("ab_settle_sr", soft_reset, 1);
        step(1);
        check("ab_settle_sr_once", soft_reset, 0);
        check("ab_settle_idle", busy, 0);

        // Abort during CAPTURE.
        do_start(8'd3, 32'd0, 32'd10000);
        check("ab_cap_clr", {error, error_code}, 0);
        step(1);
        step(5);
        pulse_index();
        step(20);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("ab_cap_code", error_code, ERR_ABORT);
        check("ab_cap_en", capture_enable, 0);
        step(1);
        check("ab_cap_idle", busy, 0);

        // Drain timeout with fifo_empty held low, limit 64.
        fifo_empty = 1'b0;
        do_start(8'd1, 32'd0, 32'd64);
        step(1);
        step(5);
        pulse_index();
        step(10);
        pulse_index();
        check("dt_drain", seq_state, ST_DRAIN);
        step(63);
        check("dt_not_yet", error, 0);
        step(1);
        check("dt_error", error, 1);
        check("dt_code", error_code, ERR_DRAIN_TIMEOUT);
        step(1);

        // Rerun clears the error; fifo_empty already high must wait a cycle.
        do_start(8'd1, 32'd0, 32'd10000);
        check("rr_clr", {error, error_code}, 0);
        step(1);
        pulse_index();
        step(9);
        fifo_empty = 1'b1;
        pulse_index();
        check("rr_drain", seq_state, ST_DRAIN);
        step(1);
        check("rr_first_drain", done, 0);
        step(1);
        check("rr_done", done, 1);
        check("rr_flux_words", flux_words, 32'd10);
        step(1);

        // num_revs 0 behaves as 1; settle 0 skips SETTLE; inputs sampled at start.
        fifo_empty = 1'b0;
        do_start(8'd0, 32'd0, 32'd10000);
        num_revs = 8'd5;
        settle_cycles = 32'd40;
        step(1);
        check("z_wait_direct", seq_state, ST_WAIT_INDEX);
        pulse_index();
        check("z_cap_en", capture_enable, 1);
        step(29);
        pulse_index();
        check("z_revs", revs_done, 1);
        check("z_drain_cap_en", capture_enable, 0);
        fifo_empty = 1'b1;
        step(1);
        step(1);
        check("z_done", done, 1);
        check("z_flux_words", flux_words, 32'd30);
        step(1);

        // Reset mid-capture drops capture_enable on the reset edge.
        fifo_empty = 1'b0;
        do_start(8'd2, 32'd0, 32'd10000);
        step(1);
        pulse_index();
        check("mr_cap_en", capture_enable, 1);
        areset = 1'b1;
        step(1);
        check("mr_cap_en_low", capture_enable, 0);
        check("mr_busy", busy, 0);
        check("mr_revs", revs_done, 0);
        areset = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
